// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: the op encoding, the flag bit
// positions and the width-generic combinational compute function.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  // Bit positions inside the 4-bit flag field {zero, neg, carry, ovf}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAG_W = 4;

  // The class exists only to give the compute function a width parameter;
  // it is never instantiated, the static method is called directly.
  virtual class alu_calc #(parameter int W = 32);

    // Shifts use only the low log2(W) bits of operand B.
    localparam int SHW = (W > 1) ? $clog2(W) : 1;

    // Returns {res, flags} with res truncated to W bits.
    static function logic [W+FLAG_W-1:0] compute(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input alu_op_e      op);
      logic [W:0]        wide;
      logic [W-1:0]      res;
      logic [SHW-1:0]    shamt;
      logic [FLAG_W-1:0] flags;
      logic              carry;
      logic              ovf;
      wide  = '0;
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      shamt = b[SHW-1:0];
      case (op)
        OP_ADD: begin
          wide  = {1'b0, a} + {1'b0, b};
          res   = wide[W-1:0];
          carry = wide[W];
          // Same-sign operands producing a differently signed sum.
          ovf   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end
        OP_SUB: begin
          wide  = {1'b0, a} - {1'b0, b};
          res   = wide[W-1:0];
          // Carry means no borrow, i.e. a >= b unsigned.
          carry = ~wide[W];
          ovf   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end
        OP_AND:  res = a & b;
        OP_OR:   res = a | b;
        OP_XOR:  res = a ^ b;
        OP_SLL:  res = a << shamt;
        OP_SRL:  res = a >> shamt;
        OP_SLT:  res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        default: res = '0;
      endcase
      flags         = '0;
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_N] = res[W-1];
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
      return {res, flags};
    endfunction

  endclass

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline slot: a valid bit with async clear plus an unreset data
// register. The slot loads when it is empty or when everything downstream
// can move; otherwise it holds its contents unchanged.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          down_free,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          advance,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          valid_reg;
  logic [DW-1:0] data_reg;

  // down_free already folds in every later stage, so this is the full
  // "empty or downstream advancing" rule without chaining through siblings.
  assign advance = !valid_reg || down_free;

  // Valid bit: cleared at once by reset, otherwise follows upstream on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (advance) begin
      valid_reg <= in_valid;
    end
  end

  // Payload: captured only when a real beat moves in; held while stalled.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      data_reg <= in_data;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake. The result is computed from the
// raw inputs and captured in stage 0; the remaining stages only delay
// {res, flags}. Backpressure propagates combinationally from out_ready.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags
);

  localparam int DW = WIDTH + FLAG_W;

  // Index 0 is the pipe input; index i+1 is the output of stage i.
  logic [LATENCY:0]   valid_chain;
  logic [DW-1:0]      data_arr [0:LATENCY];
  logic [LATENCY-1:0] adv_vec;
  logic [LATENCY-1:0] free_vec;

  assign valid_chain[0] = in_valid;
  assign data_arr[0]    = alu_calc#(WIDTH)::compute(in_a, in_b, alu_op_e'(in_op));

  // Downstream-free per stage: out_ready, or any later slot empty. Written as a
  // lookahead over valid bits so no advance signal depends on another one.
  always_comb begin
    free_vec = '0;
    for (int i = 0; i < LATENCY; i++) begin
      free_vec[i] = out_ready;
      for (int j = i + 1; j < LATENCY; j++) begin
        if (!valid_chain[j+1]) begin
          free_vec[i] = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      alu_pipe_stage #(.DW(DW)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .down_free (free_vec[gi]),
        .in_valid  (valid_chain[gi]),
        .in_data   (data_arr[gi]),
        .advance   (adv_vec[gi]),
        .out_valid (valid_chain[gi+1]),
        .out_data  (data_arr[gi+1])
      );
    end
  endgenerate

  assign in_ready  = adv_vec[0];
  assign out_valid = valid_chain[LATENCY];
  // Data regs are unreset, so gate them to show zeros whenever nothing is valid.
  assign out_res   = out_valid ? data_arr[LATENCY][DW-1:FLAG_W] : '0;
  assign out_flags = out_valid ? data_arr[LATENCY][FLAG_W-1:0]  : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: five configurations share one stimulus stream, each
// with its own scoreboard fed by an arithmetic reference model.
module tb_alu_pipe;

  localparam int NK = 5;
  localparam int WK [NK] = '{32, 8, 16, 32, 32};
  localparam int LK [NK] = '{2, 2, 2, 1, 8};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_ready;

  logic [NK-1:0] rdy;
  logic [NK-1:0] ovld;
  logic [31:0]   ores [NK];
  logic [3:0]    flg  [NK];
  logic [7:0]    res8;
  logic [15:0]   res16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_lat = 0;

  logic [35:0] exp_q [NK][$];
  int          cyc_q [NK][$];
  int          acc      [NK];
  bit          hold_v   [NK];
  logic [31:0] hold_res [NK];
  logic [3:0]  hold_flg [NK];
  bit          got      [NK];
  logic [31:0] last_res [NK];
  logic [3:0]  last_flg [NK];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .LATENCY(2)) u_w32_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ovld[0]),
    .out_ready(out_ready), .out_res(ores[0]), .out_flags(flg[0]));

  alu_pipe #(.WIDTH(8), .LATENCY(2)) u_w8_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op), .out_valid(ovld[1]),
    .out_ready(out_ready), .out_res(res8), .out_flags(flg[1]));

  alu_pipe #(.WIDTH(16), .LATENCY(2)) u_w16_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_op(in_op), .out_valid(ovld[2]),
    .out_ready(out_ready), .out_res(res16), .out_flags(flg[2]));

  alu_pipe #(.WIDTH(32), .LATENCY(1)) u_w32_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ovld[3]),
    .out_ready(out_ready), .out_res(ores[3]), .out_flags(flg[3]));

  alu_pipe #(.WIDTH(32), .LATENCY(8)) u_w32_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ovld[4]),
    .out_ready(out_ready), .out_res(ores[4]), .out_flags(flg[4]));

  assign ores[1] = {24'h0, res8};
  assign ores[2] = {16'h0, res16};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference ALU: plain integer arithmetic modulo 2^w; returns {res, z, n, c, v}.
  function automatic logic [35:0] model(input int w, input logic [31:0] ai,
                                        input logic [31:0] bi, input logic [2:0] op);
    longint unsigned m, a, b, r;
    longint as_s, bs_s;
    int sh;
    logic c, v, sa, sb;
    m  = (64'd1 << w) - 1;
    a  = ai & m;
    b  = bi & m;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    sa = a[w-1];
    sb = b[w-1];
    sh = int'(b % longint'(w));
    case (op)
      3'd0: begin r = a + b; c = r[w]; r = r & m; v = (sa == sb) && (r[w-1] != sa); end
      3'd1: begin r = (a - b) & m; c = (a >= b); v = (sa != sb) && (r[w-1] != sa); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a << sh) & m;
      3'd6: r = a >> sh;
      3'd7: begin
        as_s = sa ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        bs_s = sb ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        r = (as_s < bs_s) ? 1 : 0;
      end
      default: r = 0;
    endcase
    return {r[31:0], (r == 0), r[w-1], c, v};
  endfunction

  // Per-configuration scoreboard step, evaluated on the falling edge.
  task automatic monitor();
    logic [35:0] e;
    int c0;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        exp_q[k].delete();
        cyc_q[k].delete();
        hold_v[k] = 0;
        check($sformatf("rst_valid%0d", k), ovld[k], 0);
        check($sformatf("rst_res%0d", k), ores[k], 0);
        check($sformatf("rst_flags%0d", k), flg[k], 0);
        check($sformatf("rst_ready%0d", k), rdy[k], 1);
        continue;
      end
      if (hold_v[k]) begin
        check($sformatf("hold_valid%0d", k), ovld[k], 1);
        check($sformatf("hold_res%0d", k), ores[k], hold_res[k]);
        check($sformatf("hold_flags%0d", k), flg[k], hold_flg[k]);
      end
      if (ovld[k] && out_ready) begin
        check($sformatf("expected_beat%0d", k), exp_q[k].size() != 0, 1);
        if (exp_q[k].size() != 0) begin
          e  = exp_q[k].pop_front();
          c0 = cyc_q[k].pop_front();
          check($sformatf("res%0d", k), ores[k], e[35:4]);
          check($sformatf("flags%0d", k), flg[k], e[3:0]);
          if (chk_lat) check($sformatf("latency%0d", k), cyc - c0, LK[k]);
          last_res[k] = ores[k];
          last_flg[k] = flg[k];
          got[k] = 1;
        end
      end
      if (chk_lat) check($sformatf("stream_ready%0d", k), rdy[k], 1);
      if (in_valid && rdy[k]) begin
        exp_q[k].push_back(model(WK[k], in_a, in_b, in_op));
        cyc_q[k].push_back(cyc);
        acc[k]++;
      end
      hold_v[k]   = ovld[k] && !out_ready;
      hold_res[k] = ores[k];
      hold_flg[k] = flg[k];
    end
  endtask

  // One clock: score at the falling edge, then return 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit busy;
    in_valid  = 0;
    out_ready = 1;
    for (int n = 0; n < 60; n++) begin
      busy = 0;
      for (int k = 0; k < NK; k++) if (exp_q[k].size() != 0) busy = 1;
      if (!busy) break;
      tick();
    end
    for (int k = 0; k < NK; k++) check($sformatf("drained%0d", k), exp_q[k].size(), 0);
  endtask

  task automatic directed(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] er,
                          input logic [3:0] ef, input string tag);
    got[k]    = 0;
    in_valid  = 1;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = 1;
    tick();
    in_valid = 0;
    for (int n = 0; n < 40 && !got[k]; n++) tick();
    check({tag, "_done"}, got[k], 1);
    check({tag, "_res"}, last_res[k], er);
    check({tag, "_flags"}, last_flg[k], ef);
    $display("[TB] %s: dut%0d a=%h b=%h op=%0d res=%h flags=%b", tag, k, a, b, op,
             last_res[k], last_flg[k]);
    drain();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int b3, b4, d;
    bit done;
    for (int k = 0; k < NK; k++) begin
      acc[k] = 0; hold_v[k] = 0; got[k] = 0; last_res[k] = '0; last_flg[k] = '0;
    end
    rst_n = 1; in_valid = 1; in_a = 0; in_b = 0; in_op = 3'd0; out_ready = 1;
    #1 rst_n = 0;
    for (int n = 0; n < 3; n++) tick();

    // Streaming ADD a=i, b=2i; release reset with the first beat already valid.
    rst_n   = 1;
    chk_lat = 1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; in_a = 32'(i); in_b = 32'(2 * i); in_op = 3'd0;
      tick();
    end
    drain();
    chk_lat = 0;
    $display("[TB] streaming: 100 ADD beats issued");

    // Wrap and flags at 8 bits, shifts and compare at 16 bits.
    directed(1, 32'hFF, 32'h01, 3'd0, 32'h00, 4'b1010, "add8_wrap");
    directed(1, 32'h7F, 32'h01, 3'd0, 32'h80, 4'b0101, "add8_ovf");
    directed(2, 32'h0001, 32'h0013, 3'd5, 32'h0008, 4'b0000, "sll16");
    directed(2, 32'h8000, 32'h000F, 3'd6, 32'h0001, 4'b0000, "srl16");
    directed(2, 32'hFFFF, 32'h0001, 3'd7, 32'h0001, 4'b0000, "slt16");
    directed(0, 32'h5, 32'h9, 3'd1, 32'hFFFF_FFFC, 4'b0100, "sub32_borrow");

    // Backpressure: 6 cycles of out_ready=0 with a continuous input stream.
    for (int k = 0; k < NK; k++) hold_v[k] = 0;
    b3 = 0;
    begin
      int acc0 [NK];
      for (int k = 0; k < NK; k++) acc0[k] = acc[k];
      out_ready = 0;
      for (int n = 0; n < 6; n++) begin
        in_valid = 1; in_a = rnd_val(); in_b = rnd_val(); in_op = 3'($urandom_range(0, 7));
        tick();
      end
      for (int k = 0; k < NK; k++) begin
        d = (LK[k] < 6) ? LK[k] : 6;
        check($sformatf("bp_accepts%0d", k), acc[k] - acc0[k], d);
        check($sformatf("bp_ready%0d", k), rdy[k], (LK[k] > 6) ? 1 : 0);
      end
      $display("[TB] backpressure: accepts w32l2=%0d w32l8=%0d", acc[0] - acc0[0],
               acc[4] - acc0[4]);
    end
    drain();

    // Reset while beats are in flight.
    for (int n = 0; n < 3; n++) begin
      in_valid = 1; in_a = rnd_val(); in_b = rnd_val(); in_op = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    for (int k = 0; k < NK; k++) check($sformatf("async_clear%0d", k), ovld[k], 0);
    tick();
    rst_n = 1;
    for (int n = 0; n < 12; n++) tick();
    drain();
    $display("[TB] reset mid-flight done");

    // Random ops with random backpressure until both L=1 and L=8 saw 10k beats.
    b3 = acc[3];
    b4 = acc[4];
    done = 0;
    for (int n = 0; n < 60000; n++) begin
      if (acc[3] - b3 >= 10000 && acc[4] - b4 >= 10000) begin
        done = 1;
        break;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = rnd_val();
      in_b      = rnd_val();
      in_op     = 3'($urandom_range(0, 7));
      tick();
    end
    check("random_beats", done, 1);
    drain();
    $display("[TB] random: l1=%0d l8=%0d beats", acc[3] - b3, acc[4] - b4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
